// File: rtl/trng_pkg.sv
// -----------------------------------------------------------------------------
// trng_pkg
// Shared definitions for the TRNG read-side logic:
//   - TRNG_DATA_W     : width of one random word held in the output FIFO
//   - TRNG_FIFO_DEPTH : depth of the TRNG output FIFO (fifo64)
//   - rd_state_e      : state encoding of the PS read controller FSM
// -----------------------------------------------------------------------------
package trng_pkg;

  localparam int TRNG_DATA_W     = 64;
  localparam int TRNG_FIFO_DEPTH = 1024;

  // IDLE : no transaction outstanding
  // WAIT : request accepted, waiting for the FIFO to hold a word
  // LAT  : read strobe issued, waiting out the FIFO read latency
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    LAT  = 2'd2
  } rd_state_e;

  // Saturating increment for the 32-bit successful-read counter.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/trng_ps_reader_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Generic two-flop single-bit synchronizer with asynchronous active-low reset.
// Both flops reset to 0.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input bit
//   q     : synchronized output (two destination clock edges of latency)
// -----------------------------------------------------------------------------
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/trng_ps_reader.sv
// -----------------------------------------------------------------------------
// trng_ps_reader
// Read-side controller for the TRNG output FIFO. Each toggle of ps_req drains
// one word from the FIFO (or times out waiting for one) and answers with a
// toggle of ps_ack, with the word on ps_data. Runs in the 50 MHz TRNG domain.
// Ports:
//   clk           : TRNG clock
//   rst           : asynchronous active-low reset
//   fifo_empty    : FIFO empty flag
//   fifo_rd_en    : one-cycle FIFO read strobe (registered)
//   fifo_dout     : FIFO read data, valid RD_LATENCY cycles after rd_en sample
//   ps_req        : request toggle from GPIO (asynchronous)
//   timeout_limit : empty-wait limit in cycles, 0 = wait forever
//   ps_data       : last captured word (0 after a timeout)
//   ps_ack        : acknowledge toggle
//   ps_busy       : high while a transaction is in progress
//   ps_timeout    : last transaction ended by timeout
//   words_read    : saturating count of successful reads
// -----------------------------------------------------------------------------
module trng_ps_reader
  import trng_pkg::*;
#(
  parameter int DATA_W     = TRNG_DATA_W,
  parameter int RD_LATENCY = 1,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [DATA_W-1:0]    fifo_dout,
  input  logic                 ps_req,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  output logic [DATA_W-1:0]    ps_data,
  output logic                 ps_ack,
  output logic                 ps_busy,
  output logic                 ps_timeout,
  output logic [31:0]          words_read
);

  localparam int LAT_W = 3;

  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("trng_ps_reader: RD_LATENCY must be in 1..4");
  end

  logic req_s;

  sync2 u_req_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (ps_req),
    .q     (req_s)
  );

  rd_state_e             state_q,      state_d;
  logic                  rd_en_q,      rd_en_d;
  logic [TIMEOUT_W-1:0]  tmo_cnt_q,    tmo_cnt_d;
  logic [LAT_W-1:0]      lat_cnt_q,    lat_cnt_d;
  logic                  ack_q,        ack_d;
  logic [DATA_W-1:0]     data_q,       data_d;
  logic                  timeout_q,    timeout_d;
  logic [31:0]           words_read_q, words_read_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    rd_en_d      = 1'b0;
    tmo_cnt_d    = tmo_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    ack_d        = ack_q;
    data_d       = data_q;
    timeout_d    = timeout_q;
    words_read_d = words_read_q;

    unique case (state_q)
      IDLE: begin
        // Pending while the synchronized request differs from our ack.
        if (req_s != ack_q) begin
          state_d   = WAIT;
          tmo_cnt_d = '0;
          timeout_d = 1'b0;
        end
      end

      WAIT: begin
        if (!fifo_empty) begin
          rd_en_d   = 1'b1;
          lat_cnt_d = '0;
          state_d   = LAT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
          // Equality compare against the live limit: lowering it below the
          // current count means waiting for the counter to wrap around.
          if ((timeout_limit != '0) && (tmo_cnt_d == timeout_limit)) begin
            data_d    = '0;
            timeout_d = 1'b1;
            ack_d     = ~ack_q;
            state_d   = IDLE;
          end
        end
      end

      LAT: begin
        // Entered on the edge that registers rd_en; the FIFO samples it one
        // edge later, so data is captured RD_LATENCY+1 edges after entry.
        if (lat_cnt_q == LAT_W'(RD_LATENCY)) begin
          data_d       = fifo_dout;
          ack_d        = ~ack_q;
          words_read_d = sat_inc32(words_read_q);
          state_d      = IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rd_en_q      <= 1'b0;
      tmo_cnt_q    <= '0;
      lat_cnt_q    <= '0;
      ack_q        <= 1'b0;
      data_q       <= '0;
      timeout_q    <= 1'b0;
      words_read_q <= '0;
    end else begin
      state_q      <= state_d;
      rd_en_q      <= rd_en_d;
      tmo_cnt_q    <= tmo_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      ack_q        <= ack_d;
      data_q       <= data_d;
      timeout_q    <= timeout_d;
      words_read_q <= words_read_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign ps_data    = data_q;
  assign ps_ack     = ack_q;
  assign ps_busy    = (state_q != IDLE);
  assign ps_timeout = timeout_q;
  assign words_read = words_read_q;

endmodule

// File: doc/trng_ps_reader.md
# trng_ps_reader

Read-side controller for the TRNG output FIFO. It drains one 64-bit random word per processor-system (PS) request and presents the word to the PS through AXI GPIO. It replaces direct PS pulsing of the FIFO read enable with a toggle request/acknowledge handshake, which is robust to GPIO write timing. It sits in the 50 MHz TRNG domain between `fifo64` (read port) and the GPIO block.

## Interface
- `DATA_W`, default 64: FIFO and output word width.
- `RD_LATENCY`, default 1: cycles from the `fifo_rd_en` sample edge to valid `fifo_dout`, range 1..4.
- `TIMEOUT_W`, default 16: width of the empty-wait timeout counter.

Ports:
- `clk`, in, 1: TRNG clock (`clk_50M`).
- `rst`, in, 1: asynchronous, active-low reset.
- `fifo_empty`, in, 1: FIFO empty flag.
- `fifo_rd_en`, out, 1: FIFO read strobe; high for exactly one cycle per read.
- `fifo_dout`, in, DATA_W: FIFO read data.
- `ps_req`, in, 1: request toggle from GPIO; asynchronous to `clk`.
- `timeout_limit`, in, TIMEOUT_W: maximum number of cycles to wait for data; 0 means wait forever.
- `ps_data`, out, DATA_W: last captured word.
- `ps_ack`, out, 1: acknowledge toggle.
- `ps_busy`, out, 1: high when the FSM is not in IDLE.
- `ps_timeout`, out, 1: high if the last transaction ended by timeout.
- `words_read`, out, 32: count of successful reads; saturates at 0xFFFFFFFF.

## Operation
- `ps_req` passes through a 2-flop synchronizer reset to 0, giving `req_s`.
- Pending condition: `req_s != ps_ack`.
- Outstanding transactions: one at most. The PS toggles `ps_req` only when `ps_req == ps_ack`.

FSM states and transitions:
- IDLE: if pending, go to WAIT, clear the timeout counter, and clear `ps_timeout`.
- WAIT, `!fifo_empty`: register `fifo_rd_en=1` for one cycle, go to LAT, and clear the latency counter.
- WAIT, `fifo_empty`: increment the timeout counter.
  - When `timeout_limit != 0` and the counter reaches `timeout_limit`: set `ps_data=0`, set `ps_timeout=1`, toggle `ps_ack`, and go to IDLE.
  - `fifo_rd_en` is not issued in this case.
- LAT: count to `RD_LATENCY`, then capture `fifo_dout` into `ps_data`, toggle `ps_ack`, increment `words_read` (saturating), and go to IDLE.

Boundary conditions:
- `fifo_empty` is sampled only in WAIT. Once `fifo_rd_en` has been issued, the read completes regardless of later `fifo_empty` changes.
- If the PS toggles twice mid-transaction (a protocol violation), the pending condition is re-evaluated in IDLE after the ack toggle. The next transaction starts only if `req_s != ps_ack`; no word is dropped or duplicated.
- Changing `timeout_limit` while in WAIT takes effect immediately, using an equality compare. If the limit is lowered below the current count, the FSM waits until the counter wraps.
- Reset mid-transaction returns all state and outputs to reset values immediately. A FIFO read already issued is discarded, and that word is lost.
- The PS must drive `ps_req=0` at reset release; otherwise one transaction starts immediately.

## Timing
- Reset values: `fifo_rd_en=0`, `ps_data=0`, `ps_ack=0`, `ps_busy=0`, `ps_timeout=0`, `words_read=0`; FSM in IDLE; synchronizer flops at 0.
- Edge numbering: E0 is the first `clk` edge that samples the new `ps_req` level.
  - E1: `req_s` updates.
  - E2: IDLE goes to WAIT.
  - E3: `fifo_rd_en` is registered high, provided the FIFO is non-empty.
- Data path: the FIFO samples `rd_en` at E4. `ps_data`, `ps_ack` and `words_read` update at E(4+RD_LATENCY), which is E5 by default.
- Timeout path: `ps_ack` toggles `timeout_limit` cycles after entering WAIT.
- `ps_data` and `ps_timeout` are stable before, or on the same edge as, the `ps_ack` toggle. The PS reads data after it observes the ack.
- `ps_busy` is high from E2 until the edge on which `ps_ack` toggles.
- Maximum throughput: one word per (RD_LATENCY+4) cycles plus PS round-trip.

## Structure
- Package `trng_pkg` holds:
  - FSM state typedef (IDLE, WAIT, LAT);
  - `TRNG_DATA_W=64`;
  - `TRNG_FIFO_DEPTH=1024`.
- Sub-module `sync2`: a generic 2-flop bit synchronizer with async active-low reset, used for `ps_req`.
- Everything else stays in one FSM module.

## Test plan
- Preload FIFO with 0x0123456789ABCDEF, toggle `ps_req` 0→1 → `fifo_rd_en` one cycle at E3; `ps_data`=0x0123456789ABCDEF and `ps_ack`=1 at E5; `words_read`=1.
- FIFO empty, `timeout_limit`=0, toggle req, push 0xDEADBEEF00000001 after 100 cycles → no `fifo_rd_en` while empty; the word is delivered; `ps_timeout`=0.
- FIFO empty, `timeout_limit`=10, toggle req → `ps_ack` toggles 10 cycles after WAIT entry, `ps_data`=0, `ps_timeout`=1, no `fifo_rd_en`, `words_read` unchanged. The next successful request clears `ps_timeout`.
- Back-to-back: 8 words A0..A7, PS toggles req on each ack → 8 ordered words, exactly 8 `fifo_rd_en` pulses, `words_read`=8.
- Assert `rst` low in LAT → all outputs read 0 during reset; after release with `ps_req`=0 the FSM is idle and no spurious read occurs.
- Force `words_read`=0xFFFFFFFF, perform one read → count stays at 0xFFFFFFFF.
